// File: rtl/n_serial_subtractor.sv
// Bit-serial subtractor: D = A - B - b_in computed LSB first over N cycles,
// with valid/ready handshakes on both the operand and result sides.
module n_serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         b_in,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] D,
    output logic         b_out,
    output logic         ovf
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  res;
    logic          br;
    logic [CW-1:0] cnt;

    logic          bit_a;
    logic          bit_b;
    logic          d_bit;
    logic          br_next;
    logic [N-1:0]  res_next;

    // One full-subtractor cell; the result register fills from the MSB end.
    always_comb begin
        bit_a    = a_sh[0];
        bit_b    = b_sh[0];
        d_bit    = bit_a ^ bit_b ^ br;
        br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
        res_next = {d_bit, {(N-1){1'b0}}} | (res >> 1);
    end

    assign s_ready = (state == IDLE) && !rst;
    assign m_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            b_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        br    <= b_in;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= res_next;
                    br   <= br_next;
                    if (cnt == LAST) begin
                        // br here is the borrow into the MSB, so overflow is its
                        // disagreement with the borrow out of the MSB.
                        cnt   <= '0;
                        D     <= res_next;
                        b_out <= br_next;
                        ovf   <= br ^ br_next;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n_serial_subtractor.sv
// Self-checking bench for n_serial_subtractor: directed cases, backpressure,
// mid-operation reset and randomized operations against an arithmetic model.
module tb_n_serial_subtractor;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         b_in;
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] D;
    logic         b_out;
    logic         ovf;

    int checks = 0;
    int passed = 0;

    n_serial_subtractor #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .A       (A),
        .B       (B),
        .b_in    (b_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .D       (D),
        .b_out   (b_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain wide arithmetic for the unsigned borrow and signed range for overflow.
    task automatic refModel(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                            output logic [N-1:0] d, output logic bo, output logic ov);
        logic [N:0] u;
        int s;
        u  = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
        d  = u[N-1:0];
        bo = u[N];
        s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ov = (s < -(2 ** (N-1))) || (s > (2 ** (N-1)) - 1);
    endtask

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                                 input int delay);
        logic [N-1:0] ed;
        logic eb, eo;
        int t, lat;
        refModel(a, b, bin, ed, eb, eo);
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkOutput("s_ready_idle", 32'(s_ready), 32'd1);
        A = a; B = b; b_in = bin; s_valid = 1'b1;
        m_ready = (delay == 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        A = N'($urandom); B = N'($urandom); b_in = 1'($urandom);
        lat = 0;
        while (!m_valid && lat < 4 * N) begin
            @(posedge clk);
            #1;
            lat++;
            A = N'($urandom); B = N'($urandom);
        end
        checkOutput("latency", 32'(lat), 32'(N));
        checkOutput("D", 32'(D), 32'(ed));
        checkOutput("b_out", 32'(b_out), 32'(eb));
        checkOutput("ovf", 32'(ovf), 32'(eo));
        for (int k = 0; k < delay; k++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_m_valid", 32'(m_valid), 32'd1);
            checkOutput("hold_D", 32'({b_out, ovf, D}), 32'({eb, eo, ed}));
            checkOutput("hold_s_ready", 32'(s_ready), 32'd0);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checkOutput("m_valid_fall", 32'(m_valid), 32'd0);
        checkOutput("s_ready_after", 32'(s_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] da [5];
        logic [N-1:0] db [5];
        logic         dbin [5];
        da   = '{8'd5, 8'd30, 8'd5, 8'd127, 8'h80};
        db   = '{8'd10, 8'hF6, 8'd10, 8'hFF, 8'd1};
        dbin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        A = '0; B = '0; b_in = 1'b0;
        #12;
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_D", 32'(D), 32'd0);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("release_s_ready", 32'(s_ready), 32'd1);

        $display("[TB] directed cases");
        for (int i = 0; i < 5; i++) applyStimulus(da[i], db[i], dbin[i], 0);

        $display("[TB] backpressure");
        applyStimulus(8'd77, 8'd200, 1'b1, 3);
        applyStimulus(8'h80, 8'd1, 1'b0, 2);

        $display("[TB] reset mid-operation");
        @(negedge clk);
        A = 8'd99; B = 8'd3; b_in = 1'b0; s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("midrst_D", 32'(D), 32'd0);
        checkOutput("midrst_ovf", 32'(ovf), 32'd0);
        checkOutput("midrst_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_release_s_ready", 32'(s_ready), 32'd1);
        applyStimulus(8'd0, 8'd0, 1'b1, 0);

        $display("[TB] random operations");
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
